// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the shared-memory port arbiter.
//   arb_state_e : arbiter FSM states (free arbitration / locked to one owner)
//   DEF_ADDR_W  : default memory word address width (2048 words)
//   DEF_DATA_W  : default memory data width
//   rot_idx()   : round-robin index arithmetic, (base + off) mod n
package mem_arb_pkg;

    typedef enum logic {
        StArb    = 1'b0,
        StLocked = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_ADDR_W = 11;
    localparam int unsigned DEF_DATA_W = 32;

    function automatic int unsigned rot_idx(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker, shared with other arbiters.
// Scans the eligible vector starting at ptr_i and wrapping modulo N.
//   elig_i : eligible requesters
//   ptr_i  : highest-priority index this cycle
//   gnt_o  : one-hot winner (0 when nothing eligible)
//   idx_o  : binary index of the winner (0 when nothing eligible)
//   any_o  : at least one requester eligible
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     elig_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDX_W'(rot_idx(32'(ptr_i), k, N));
            if (!any_o && elig_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one read/write port of a 1-cycle-latency memory
// among NUM_REQ cores, with a lock for atomic sequences and a lock timeout.
//   clk_i, reset_i          : clock, synchronous active-high reset
//   req_i/req_we_i/req_lock_i : per-requester request, write flag, lock request
//   req_adrs_i/req_wdata_i  : flattened per-requester address / write data
//   gnt_o                   : one-hot combinational grant
//   rsp_valid_o/rsp_rdata_o : routed read return (one-hot valid, shared data)
//   mem_*                   : memory port (shared address for read and write)
//   lock_timeout_o          : one-cycle pulse after a forced lock release
//   busy_locked_o           : registered, high while locked
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ-1:0]        req_lock_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_adrs_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic                      mem_r_en_o,
    output logic                      mem_w_en_o,
    output logic [ADDR_W-1:0]         mem_adrs_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    input  logic                      mem_r_valid_i,
    output logic                      lock_timeout_o,
    output logic                      busy_locked_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             pend_valid_q, pend_valid_d;
    logic [IDX_W-1:0] pend_id_q, pend_id_d;
    logic             lock_timeout_q, lock_timeout_d;
    logic             busy_locked_q;

    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               grant;
    logic               g_we;

    always_comb begin
        owner_oh           = '0;
        owner_oh[owner_q]  = 1'b1;
        elig = (state_q == StLocked) ? (req_i & owner_oh) : req_i;
    end

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .elig_i (elig),
        .ptr_i  (rr_ptr_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // Reset blocks all memory traffic regardless of the request inputs.
    assign grant = pick_any & ~reset_i;
    assign g_we  = req_we_i[pick_idx];

    always_comb begin
        gnt_o       = grant ? pick_gnt : '0;
        mem_w_en_o  = grant & g_we;
        mem_r_en_o  = grant & ~g_we;
        mem_adrs_o  = grant ? req_adrs_i[pick_idx*ADDR_W +: ADDR_W] : '0;
        mem_wdata_o = grant ? req_wdata_i[pick_idx*DATA_W +: DATA_W] : '0;
    end

    // Read return is routed combinationally to the requester that issued it.
    always_comb begin
        rsp_valid_o = '0;
        if (pend_valid_q && mem_r_valid_i && !reset_i) begin
            rsp_valid_o[pend_id_q] = 1'b1;
        end
        rsp_rdata_o = mem_rdata_i;
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        rr_ptr_d       = rr_ptr_q;
        lock_cnt_d     = lock_cnt_q;
        lock_timeout_d = 1'b0;
        pend_valid_d   = grant & ~g_we;
        pend_id_d      = (grant && !g_we) ? pick_idx : pend_id_q;

        if (grant) begin
            rr_ptr_d = IDX_W'(rot_idx(32'(pick_idx), 1, NUM_REQ));
        end

        unique case (state_q)
            StArb: begin
                if (grant && req_lock_i[pick_idx]) begin
                    state_d    = StLocked;
                    owner_d    = pick_idx;
                    lock_cnt_d = '0;
                end
            end
            StLocked: begin
                lock_cnt_d = lock_cnt_q + 1'b1;
                // Voluntary release takes precedence over the timeout.
                if ((grant && !req_lock_i[owner_q]) ||
                    (!req_i[owner_q] && !req_lock_i[owner_q])) begin
                    state_d    = StArb;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
                    state_d        = StArb;
                    lock_cnt_d     = '0;
                    lock_timeout_d = 1'b1;
                    rr_ptr_d       = IDX_W'(rot_idx(32'(owner_q), 1, NUM_REQ));
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= StArb;
            owner_q        <= '0;
            rr_ptr_q       <= '0;
            lock_cnt_q     <= '0;
            pend_valid_q   <= 1'b0;
            pend_id_q      <= '0;
            lock_timeout_q <= 1'b0;
            busy_locked_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            rr_ptr_q       <= rr_ptr_d;
            lock_cnt_q     <= lock_cnt_d;
            pend_valid_q   <= pend_valid_d;
            pend_id_q      <= pend_id_d;
            lock_timeout_q <= lock_timeout_d;
            busy_locked_q  <= (state_d == StLocked);
        end
    end

    assign lock_timeout_o = lock_timeout_q;
    assign busy_locked_o  = busy_locked_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 11;
    localparam int unsigned DW = 32;
    localparam int unsigned LM = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req, req_we, req_lock;
    logic [N*AW-1:0]   req_adrs;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      gnt, rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              mem_r_en, mem_w_en;
    logic [AW-1:0]     mem_adrs;
    logic [DW-1:0]     mem_wdata, mem_rdata;
    logic              mem_r_valid;
    logic              lock_timeout, busy_locked;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_REQ  (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .LOCK_MAX (LM)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .req_i          (req),
        .req_we_i       (req_we),
        .req_lock_i     (req_lock),
        .req_adrs_i     (req_adrs),
        .req_wdata_i    (req_wdata),
        .gnt_o          (gnt),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .mem_r_en_o     (mem_r_en),
        .mem_w_en_o     (mem_w_en),
        .mem_adrs_o     (mem_adrs),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .mem_r_valid_i  (mem_r_valid),
        .lock_timeout_o (lock_timeout),
        .busy_locked_o  (busy_locked)
    );

    // Contents of never-written words.
    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return 32'hA5A5_0000 | {21'b0, a};
    endfunction

    // Memory environment: 2048x32, one-cycle read latency.
    logic [DW-1:0] env_mem [2048];
    bit            env_wr  [2048];
    always @(posedge clk) begin
        mem_r_valid <= mem_r_en;
        if (mem_r_en === 1'b1) mem_rdata <= env_wr[mem_adrs] ? env_mem[mem_adrs] : init_word(mem_adrs);
        if (mem_w_en === 1'b1) begin
            env_mem[mem_adrs] <= mem_wdata;
            env_wr[mem_adrs]  <= 1'b1;
        end
    end

    int checks = 0;
    int failures = 0;

    // Requester-side stimulus state.
    logic          r_req [N];
    logic          r_we [N];
    logic          r_lock [N];
    logic [AW-1:0] r_adrs [N];
    logic [DW-1:0] r_wdata [N];
    bit            sticky [N];
    bit            rand_mode = 1'b0;
    bit            prev_pend [N];
    logic [AW-1:0] prev_adrs [N];
    logic          prev_we [N];

    // Reference model, expressed in terms of the arbitration rules.
    logic [DW-1:0] ref_mem [2048];
    bit            ref_wr  [2048];
    bit            m_lock;
    int            m_owner, m_ptr, m_held;
    bit            m_pend;
    int            m_pend_id;
    logic [DW-1:0] m_pend_data;
    bit            exp_to, exp_busy;
    int            last_g;

    int  dut_log[$];
    bit  dut_to_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i] === 1'b1) r = (r == -1) ? i : -2;
        if ($isunknown(v)) r = -3;
        return r;
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_wr[a] ? ref_mem[a] : init_word(a);
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]                = r_req[i];
            req_we[i]             = r_we[i];
            req_lock[i]           = r_lock[i];
            req_adrs[i*AW +: AW]  = r_adrs[i];
            req_wdata[i*DW +: DW] = r_wdata[i];
        end
    endtask

    task automatic model_cycle();
        int           g;
        logic [N-1:0] exp_gnt, exp_rsp;
        bit           owner_req, owner_lock;

        dut_log.push_back(oh2idx(gnt));
        dut_to_seen = (lock_timeout === 1'b1);

        // Held requests must keep address and direction until granted.
        for (int i = 0; i < N; i++) begin
            if (prev_pend[i] && r_req[i]) begin
                chk($sformatf("proto_adrs%0d", i), r_adrs[i], prev_adrs[i]);
                chk($sformatf("proto_we%0d", i), r_we[i], prev_we[i]);
            end
        end

        if (reset) begin
            chk("rst_gnt", gnt, '0);
            chk("rst_ren", mem_r_en, 1'b0);
            chk("rst_wen", mem_w_en, 1'b0);
            chk("rst_rsp", rsp_valid, '0);
            m_lock = 0; m_ptr = 0; m_held = 0; m_pend = 0;
            exp_to = 0; exp_busy = 0; last_g = -1;
            for (int i = 0; i < N; i++) prev_pend[i] = 1'b0;
            return;
        end

        exp_rsp = '0;
        if (m_pend) exp_rsp[m_pend_id] = 1'b1;
        chk("rsp_valid", rsp_valid, exp_rsp);
        if (m_pend) chk("rsp_rdata", rsp_rdata, m_pend_data);
        chk("lock_timeout", lock_timeout, exp_to);
        chk("busy_locked", busy_locked, exp_busy);

        // First eligible requester at or after the pointer, wrapping.
        g = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (g < 0 && r_req[i] && (!m_lock || i == m_owner)) g = i;
        end
        exp_gnt = '0;
        if (g >= 0) exp_gnt[g] = 1'b1;
        chk("gnt", gnt, exp_gnt);
        chk("mem_r_en", mem_r_en, (g >= 0) && !r_we[g]);
        chk("mem_w_en", mem_w_en, (g >= 0) && r_we[g]);
        if (g >= 0) begin
            chk("mem_adrs", mem_adrs, r_adrs[g]);
            if (r_we[g]) chk("mem_wdata", mem_wdata, r_wdata[g]);
        end

        for (int i = 0; i < N; i++) begin
            prev_pend[i] = r_req[i] && (g != i);
            prev_adrs[i] = r_adrs[i];
            prev_we[i]   = r_we[i];
        end

        m_pend = 0;
        exp_to = 0;
        if (g >= 0) begin
            m_ptr = (g + 1) % N;
            if (r_we[g]) begin
                ref_mem[r_adrs[g]] = r_wdata[g];
                ref_wr[r_adrs[g]]  = 1'b1;
            end else begin
                m_pend      = 1;
                m_pend_id   = g;
                m_pend_data = ref_read(r_adrs[g]);
            end
        end
        if (!m_lock) begin
            if (g >= 0 && r_lock[g]) begin
                m_lock = 1; m_owner = g; m_held = 0;
            end
        end else begin
            m_held++;
            owner_req  = r_req[m_owner];
            owner_lock = r_lock[m_owner];
            if ((g >= 0 && !owner_lock) || (!owner_req && !owner_lock)) begin
                m_lock = 0;
            end else if (m_held == LM) begin
                m_lock = 0;
                exp_to = 1;
                m_ptr  = (m_owner + 1) % N;
            end
        end
        exp_busy = m_lock;
        last_g   = g;
    endtask

    task automatic update_requesters();
        int a;
        if (last_g >= 0 && !sticky[last_g]) r_req[last_g] = 1'b0;
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!r_req[i] && $urandom_range(0, 2) == 0) begin
                    a          = $urandom_range(0, 15);
                    r_req[i]   = 1'b1;
                    r_we[i]    = ($urandom_range(0, 2) == 0);
                    r_lock[i]  = ($urandom_range(0, 7) == 0);
                    r_adrs[i]  = (a < 8) ? AW'(a) : AW'(2040 + a - 8);
                    r_wdata[i] = $urandom;
                end
            end
        end
    endtask

    task automatic tick();
        drive();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        update_requesters();
    endtask

    task automatic set_req(input int i, input logic we, input logic lk,
                           input int unsigned a, input logic [DW-1:0] d);
        r_req[i] = 1'b1; r_we[i] = we; r_lock[i] = lk;
        r_adrs[i] = AW'(a); r_wdata[i] = d;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            r_req[i] = 1'b0; r_lock[i] = 1'b0; sticky[i] = 1'b0;
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            r_req[i] = 0; r_we[i] = 0; r_lock[i] = 0; r_adrs[i] = '0; r_wdata[i] = '0;
            sticky[i] = 0; prev_pend[i] = 0; prev_adrs[i] = '0; prev_we[i] = 0;
        end
        last_g = -1;
        reset = 1'b1;

        // Reset with all requesters asserting: no grant may escape.
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 200 + i, '0);
        tick(); tick();
        clear_all();
        reset = 1'b0;
        tick();

        // Single requester: write 0xF to 30, then read it back.
        set_req(1, 1'b1, 1'b0, 30, 32'h0000_000F);
        tick();
        set_req(1, 1'b0, 1'b0, 30, '0);
        tick(); tick();

        // Fairness from reset: four sticky readers.
        reset = 1'b1; tick(); reset = 1'b0;
        dut_log.delete();
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b0, 1'b0, 100 + i, '0);
            sticky[i] = 1'b1;
        end
        for (int k = 0; k < 8; k++) tick();
        for (int k = 0; k < 8; k++) chk($sformatf("fair_order%0d", k), dut_log[k], k % 4);
        clear_all();
        tick();

        // Write then read at the top of memory.
        set_req(2, 1'b1, 1'b0, 2046, 32'hDEAD_BEEF);
        tick();
        set_req(0, 1'b0, 1'b0, 2046, '0);
        tick(); tick(); tick();

        // Lock held by requester 3 while 0 and 1 wait.
        dut_log.delete();
        set_req(3, 1'b0, 1'b1, 5, '0);
        tick();
        set_req(0, 1'b0, 1'b0, 6, '0);
        set_req(1, 1'b0, 1'b0, 7, '0);
        set_req(3, 1'b0, 1'b1, 5, '0);
        sticky[3] = 1'b1;
        tick(); tick(); tick();
        sticky[3] = 1'b0;
        set_req(3, 1'b1, 1'b0, 5, 32'h0000_1234);
        tick(); tick(); tick();
        chk("lock_seq0", dut_log[0], 3);
        chk("lock_seq4", dut_log[4], 3);
        chk("lock_seq5", dut_log[5], 0);
        chk("lock_seq6", dut_log[6], 1);
        tick(); tick();

        // Lock timeout: requester 1 never releases, requester 2 waits.
        set_req(1, 1'b0, 1'b1, 9, '0);
        sticky[1] = 1'b1;
        tick();
        set_req(2, 1'b0, 1'b0, 10, '0);
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (dut_to_seen) break;
        end
        chk("timeout_ticks", n, LM + 1);
        chk("after_timeout_gnt", dut_log[$], 2);
        clear_all();
        tick(); tick();

        // Reset right after a granted read.
        set_req(0, 1'b0, 1'b0, 11, '0);
        tick();
        reset = 1'b1;
        set_req(3, 1'b0, 1'b0, 12, '0);
        tick();
        reset = 1'b0;
        set_req(0, 1'b0, 1'b0, 13, '0);
        set_req(1, 1'b0, 1'b0, 14, '0);
        set_req(2, 1'b0, 1'b0, 15, '0);
        tick();
        chk("post_reset_gnt", dut_log[$], 0);
        for (int k = 0; k < 5; k++) tick();

        // Randomized traffic with occasional reset.
        clear_all();
        rand_mode = 1'b1;
        for (int k = 0; k < 600; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter that lets NUM_REQ cores share one read/write port pair of the 2048x32 shared memory. Each core requester port drives one address/data/enable set.
- Grants at most one access per cycle and routes the 1-cycle-latency read data back to the requester that issued the read.
- Supports a lock so one core can keep the port for atomic read-modify-write sequences, with a timeout to prevent starvation.
- Sits between the core load/store stages and the memory's r_en/r_adrs/data_out and w_en/w_adrs/data_in pins.

Parameters:
- NUM_REQ, 4, number of requesting cores (2..8).
- ADDR_W, 11, memory word address width.
- DATA_W, 32, memory data width.
- LOCK_MAX, 16, maximum number of cycles a lock may be held before it is forcibly released.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester access request; held until granted.
- req_we  input  NUM_REQ  1 = write, 0 = read.
- req_lock  input  NUM_REQ  request or keep exclusive ownership.
- req_adrs  input  NUM_REQ*ADDR_W  flattened addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*DATA_W  flattened write data.
- gnt  output  NUM_REQ  one-hot, combinational; access accepted this cycle.
- rsp_valid  output  NUM_REQ  one-hot; read data for requester i is valid.
- rsp_rdata  output  DATA_W  read data, shared by all requesters.
- mem_r_en  output  1  memory read enable.
- mem_w_en  output  1  memory write enable.
- mem_adrs  output  ADDR_W  address, driven to both r_adrs and w_adrs.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory data_out.
- mem_r_valid  input  1  memory read-valid.
- lock_timeout  output  1  one-cycle pulse when a lock is forcibly released.
- busy_locked  output  1  high while the FSM is in LOCKED.

Behaviour:
- Reset (reset=1 at posedge):
  - state=ARB, rr_ptr=0, lock_cnt=0.
  - rsp_valid=0, lock_timeout=0, pend_valid=0.
  - While reset is high, gnt=0, mem_r_en=0 and mem_w_en=0, independent of req.
- FSM states:
  - ARB: the eligible set is req.
  - LOCKED(owner): the eligible set is req & (1<<owner); all other requesters stall with gnt=0.
- Pick:
  - Choose the first eligible index scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - If the eligible set is empty: gnt=0, mem_r_en=0, mem_w_en=0; mem_adrs and mem_wdata are don't-care, driven 0.
- Grant cycle for index g:
  - gnt[g]=1.
  - mem_adrs and mem_wdata come from slice g.
  - mem_w_en=req_we[g] and mem_r_en=!req_we[g].
  - At the posedge: rr_ptr <= (g+1) mod NUM_REQ.
- Read return:
  - On a granted read, register pend_id=g and pend_valid=1.
  - The next cycle, when mem_r_valid=1, drive rsp_valid[pend_id]=1 and rsp_rdata=mem_rdata.
  - Total read latency is 1 cycle after gnt. Back-to-back reads from different requesters every cycle are allowed.
- Writes: gnt is the only acknowledgement. There is no rsp_valid for writes.
- Lock entry: in ARB, a grant with req_lock[g]=1 moves the FSM to LOCKED with owner=g and lock_cnt=0.
- Lock exit (LOCKED to ARB), on whichever of these comes first:
  - The owner is granted with req_lock=0. That access completes normally.
  - The owner has req=0 and req_lock=0.
  - lock_cnt reaches LOCK_MAX-1. lock_timeout pulses for 1 cycle, and rr_ptr is set to owner+1.
- lock_cnt increments every cycle spent in LOCKED.
- busy_locked is registered and equals (state==LOCKED).
- Simultaneous events:
  - A grant and the lock timeout in the same cycle: the access completes, then the FSM returns to ARB.
  - A read return and a new grant overlap by design.
- Reset mid-operation: a pending read is discarded. rsp_valid is 0 in the cycle after reset even if mem_r_valid=1.
- Protocol errors: a requester changing req_adrs or req_we while req=1 and gnt=0 is a protocol violation. The bench asserts against it; the RTL does not check.

Decomposition:
- Package mem_arb_pkg holds:
  - The state enum {ARB, LOCKED}.
  - Default widths ADDR_W=11 and DATA_W=32.
  - A function for rotate-index arithmetic.
- Sub-module rr_pick: purely combinational. Inputs are the eligible vector and rr_ptr; outputs are a one-hot grant, the index and an any flag. It is reused by future I/O arbiters.
- The top level holds the FSM, pending-read register and lock counter.

Test Plan:
- Single requester: req[1] read at adrs 30, where the memory holds 0x0000000F. Expect gnt[1] the same cycle and rsp_valid[1]=1 with rsp_rdata=0xF one cycle later.
- Fairness: all 4 requesters hold read requests for 8 cycles from reset. Expect grant order 0,1,2,3,0,1,2,3 and each rsp_valid routed to the matching id.
- Write then read: req[2] writes 0xDEADBEEF to 2046, then req[0] reads 2046. Expect mem_w_en for 1 cycle, then rsp_rdata=0xDEADBEEF to requester 0 only.
- Lock: req[3] reads with lock=1 while req[0] and req[1] are pending. Expect only requester 3 granted until it writes with lock=0. Requester 0 is then granted next, and busy_locked falls.
- Timeout: req[1] holds lock=1 with continuous requests, LOCK_MAX=16. Expect lock_timeout after 16 LOCKED cycles, then requester 2 (pending) granted next.
- Reset mid-read: assert reset in the cycle after a granted read. Expect rsp_valid=0, gnt=0 during reset, and rr_ptr restarting at 0 afterwards.
